// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared RV32I opcode constants, instruction-format enum, FIFO entry type and
//   the opcode/funct3 -> format classifier used by the instruction encoder.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] INST_LOAD   = 7'b000_0011;
  localparam logic [6:0] INST_OP_IMM = 7'b001_0011;
  localparam logic [6:0] INST_AUIPC  = 7'b001_0111;
  localparam logic [6:0] INST_STORE  = 7'b010_0011;
  localparam logic [6:0] INST_OP     = 7'b011_0011;
  localparam logic [6:0] INST_LUI    = 7'b011_0111;
  localparam logic [6:0] INST_BRANCH = 7'b110_0011;
  localparam logic [6:0] INST_JALR   = 7'b110_0111;
  localparam logic [6:0] INST_JAL    = 7'b110_1111;

  // funct3 codes that turn OP-IMM into a shift-immediate
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  // Canonical NOP (addi x0, x0, 0), emitted for unknown opcodes
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SHIFT,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

  function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
    fmt_e fmt;
    case (opcode)
      INST_OP:                fmt = FMT_R;
      INST_OP_IMM:            fmt = (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) ? FMT_SHIFT : FMT_I;
      INST_LOAD, INST_JALR:   fmt = FMT_I;
      INST_STORE:             fmt = FMT_S;
      INST_BRANCH:            fmt = FMT_B;
      INST_LUI, INST_AUIPC:   fmt = FMT_U;
      INST_JAL:               fmt = FMT_J;
      default:                fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//   Request/response bundle of the instruction encoder.
//   Request side : in_valid/in_ready handshake plus opcode, funct3/7, rd, rs1,
//                  rs2 and 32-bit immediate.
//   Response side: out_valid/out_ready handshake plus encoded word, byte
//                  address, range-error flag and saturating error count.
//   master = producer/consumer around the encoder, slave = the encoder.
// -----------------------------------------------------------------------------
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// -----------------------------------------------------------------------------
// instr_encoder_imm_pack
//   Combinational: classifies the request format and scatters the immediate
//   into its instruction-word bit positions (all other bits zero), flagging
//   immediates that do not fit the format.
//   i_opcode, i_funct3 : format selection
//   i_imm              : signed byte immediate (full value for U-type)
//   o_fmt              : instruction format
//   o_imm_bits         : immediate bits in place, truncated when out of range
//   o_err              : range violation or unknown opcode
// -----------------------------------------------------------------------------
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output fmt_e        o_fmt,
  output logic [31:0] o_imm_bits,
  output logic        o_err
);

  fmt_e w_fmt;
  logic w_fits_12;
  logic w_fits_13;
  logic w_fits_21;

  assign w_fmt = fmt_of(i_opcode, i_funct3);
  assign o_fmt = w_fmt;

  // A value fits an N-bit signed field when every bit above N-2 equals the sign.
  assign w_fits_12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
  assign w_fits_13 = (i_imm[31:12] == '0) || (i_imm[31:12] == '1);
  assign w_fits_21 = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    o_imm_bits = '0;
    o_err      = 1'b0;
    case (w_fmt)
      FMT_I: begin
        o_imm_bits = {i_imm[11:0], 20'd0};
        o_err      = !w_fits_12;
      end
      FMT_SHIFT: begin
        o_imm_bits = {7'd0, i_imm[4:0], 20'd0};
        o_err      = (i_imm[31:5] != '0);
      end
      FMT_S: begin
        o_imm_bits = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
        o_err      = !w_fits_12;
      end
      FMT_B: begin
        o_imm_bits = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
        o_err      = !w_fits_13 || i_imm[0];
      end
      FMT_U: begin
        o_imm_bits = {i_imm[31:12], 12'd0};
        o_err      = (i_imm[11:0] != '0);
      end
      FMT_J: begin
        o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
        o_err      = !w_fits_21 || i_imm[0];
      end
      FMT_BAD: o_err = 1'b1;
      default: o_err = 1'b0;   // FMT_R carries no immediate
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs opcode, register fields, funct fields and immediate into an RV32I
//   instruction word. Results go through a 2-entry FIFO; the head entry is
//   tagged with a byte address that steps by ADDR_STEP on every pop.
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   flush : synchronous clear (FIFO empty, address = BASE_ADDR, err_cnt = 0);
//           wins over a same-cycle push or pop
//   bus   : request/response bundle (see instr_encoder_if)
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  instr_encoder_if.slave bus
);

  fmt_e        w_fmt;
  logic [31:0] w_imm_bits;
  logic        w_imm_err;
  logic [31:0] w_word;
  entry_t      w_entry;
  entry_t      w_head;
  logic        w_full;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;

  entry_t      r_mem [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic [31:0] r_addr;
  logic [7:0]  r_err_cnt;

  instr_encoder_imm_pack u_imm_pack (
    .i_opcode   (bus.in_opcode),
    .i_funct3   (bus.in_funct3),
    .i_imm      (bus.in_imm),
    .o_fmt      (w_fmt),
    .o_imm_bits (w_imm_bits),
    .o_err      (w_imm_err)
  );

  // Register fields are inserted only for formats that encode them.
  always_comb begin
    w_word = INST_NOP;
    case (w_fmt)
      FMT_R:        w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              bus.in_rd, bus.in_opcode};
      FMT_I:        w_word = w_imm_bits | {12'd0, bus.in_rs1, bus.in_funct3,
                                           bus.in_rd, bus.in_opcode};
      FMT_SHIFT:    w_word = w_imm_bits | {bus.in_funct7, 5'd0, bus.in_rs1, bus.in_funct3,
                                           bus.in_rd, bus.in_opcode};
      FMT_S, FMT_B: w_word = w_imm_bits | {7'd0, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                           5'd0, bus.in_opcode};
      FMT_U, FMT_J: w_word = w_imm_bits | {20'd0, bus.in_rd, bus.in_opcode};
      default:      w_word = INST_NOP;
    endcase
  end

  assign w_entry = '{instr: w_word, err: w_imm_err};

  assign w_full      = (r_count == 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_head      = r_mem[r_head];

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign bus.in_ready = !w_full || (w_out_valid && bus.out_ready);
  assign w_push       = bus.in_valid && bus.in_ready && !flush;
  assign w_pop        = w_out_valid && bus.out_ready && !flush;

  // Outputs come from registers only; stale storage is hidden while empty.
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_head.instr : '0;
  assign bus.out_err   = w_out_valid && w_head.err;
  assign bus.out_addr  = r_addr;
  assign bus.err_cnt   = r_err_cnt;

  // NOTE: FIFO storage has no reset; nothing reads an entry before it is written,
  // and out_* are masked by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_addr    <= BASE_ADDR;
      r_err_cnt <= 8'd0;
    end else if (flush) begin
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_addr    <= BASE_ADDR;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head <= r_head + 1'b1;
        r_addr <= r_addr + ADDR_STEP;   // wraps modulo 2^32
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_imm_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
